alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
Parametrised sequential ALU core, the successor to the fixed 8-bit combinational ALU datapath. Holds two operand registers loaded over one shared input bus. Executes eight operations under a start/busy/done handshake: add, sub, and, or, xor, shl, shr and an iterative shift-add multiply. Produces a registered result, per-operation flags and sticky flags for the board-level display/top wrapper.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
SHW, $clog2(WIDTH)+1, shift-amount width (derived; not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when low all inputs are ignored and state holds
in_data  input  WIDTH  operand load bus
in_sel  input  1  load target: 0=A, 1=B
in_load  input  1  load strobe
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
shamt  input  SHW  shift amount for SHL/SHR
start  input  1  start request
flag_clr  input  1  clear sticky flags
busy  output  1  high while a MUL is iterating
done  output  1  one-cycle pulse when result/flags update
result  output  WIDTH  result (low half for MUL)
result_hi  output  WIDTH  MUL high half; 0 for other ops
zero, carry, overflow, negative  output  1 each  flags of last completed op
sticky  output  4  {zero,carry,overflow,negative} OR-accumulated since last clear

Behaviour:
- Reset (async, rst_n=0): A, B, result, result_hi, all flags, sticky, counter = 0; done=0, busy=0; FSM=IDLE. Reset mid-MUL aborts the operation with no done.
- Load: in IDLE with ena & in_load, the selected register takes in_data at the edge. Loads while busy are ignored.
- FSM IDLE: ena & start & op!=MUL -> compute from current A/B (values before any same-edge load). Register result and flags at that edge; done=1 the following cycle (latency 1); stay IDLE.
- IDLE, ena & start & op==MUL: latch A/B into the multiplier, clear the accumulator, counter=0, busy=1 -> MUL.
- MUL: one shift-add step per enabled cycle, counter increments. After step WIDTH-1: register the 2W product, done=1, busy=0 -> IDLE. done is therefore high in the cycle after edge N+WIDTH, where N is the start edge. ena low freezes the counter.
- start while busy: ignored. Back-to-back single-cycle starts: one done per start.
- Arithmetic is unsigned WIDTH-bit, with wrap-around.
  - ADD: carry = carry-out. overflow = signed overflow (operand signs equal, result sign differs).
  - SUB: A-B; carry = borrow (1 iff A<B unsigned). overflow = signed overflow (operand signs differ, result sign differs from A).
  - AND/OR/XOR: carry=0, overflow=0.
  - SHL/SHR: carry = last bit shifted out. shamt=0 -> result=A, carry=0. shamt>=WIDTH -> result=0, carry=0. overflow=0.
  - MUL: carry = (result_hi!=0), overflow=0.
- zero = (result==0), or for MUL ({result_hi,result}==0). negative = MSB of result, or for MUL the MSB of result_hi.
- Flags and result hold until the next done.
- Sticky: on done, sticky |= new flags. flag_clr with no done clears to 0. flag_clr and done in the same cycle: sticky = new flags only.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- ADD wrap: A=0xFF, B=0x01, start -> next cycle done=1, result=0x00, zero=1, carry=1, overflow=0, negative=0.
- Signed overflow: ADD 0x7F+0x01 -> result=0x80, overflow=1, negative=1. SUB 0x05-0x07 -> result=0xFE, carry=1, overflow=0, negative=1.
- Shifts: SHL A=0x81 shamt=1 -> 0x02, carry=1. SHR A=0x81 shamt=1 -> 0x40, carry=1. SHL shamt=9 -> 0x00, carry=0, zero=1.
- MUL: A=0xFF, B=0xFF, start at edge N -> busy=1 for 8 cycles, done after edge N+8, result_hi=0xFE, result=0x01, carry=1. start and in_load pulses during busy leave A, B and the outcome unchanged.
- Reset mid-MUL: assert rst_n=0 at cycle 3 of a MUL -> all outputs 0 immediately, no done. A new MUL after release completes normally.
- Sticky: ADD giving carry, then AND giving zero -> sticky={1,1,0,0}. flag_clr alone -> 0000. flag_clr coincident with a done of ADD 0x7F+0x01 -> sticky={0,0,1,1}. ena=0 with start -> no done, state frozen.

Source files
------------

// File: rtl/alu_seq_core.sv
// Sequential ALU core: two operand registers, single-cycle logic/arith/shift ops
// and an iterative shift-add multiplier, with registered result, flags and sticky flags.
module alu_seq_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_load,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic             start,
    input  logic             flag_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic [3:0]       sticky
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]    mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d, sticky_q, sticky_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]   sum, diff, shl_t, shr_t;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [PW-1:0]    mul_add, acc_nxt;
    logic [3:0]       sticky_base;

    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign shl_t = {1'b0, a_q} << shamt;
    assign shr_t = {a_q, 1'b0} >> shamt;

    // Single-cycle operations; the extra bit of the shift temporaries holds the last bit shifted out
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                if (shamt == '0) begin
                    alu_res = a_q;
                end else if (shamt < SHW'(WIDTH)) begin
                    alu_res = shl_t[WIDTH-1:0];
                    alu_c   = shl_t[WIDTH];
                end
            end
            OP_SHR: begin
                if (shamt == '0) begin
                    alu_res = a_q;
                end else if (shamt < SHW'(WIDTH)) begin
                    alu_res = shr_t[WIDTH:1];
                    alu_c   = shr_t[0];
                end
            end
            default: ;
        endcase
    end

    assign mul_add     = mplier_q[0] ? mcand_q : '0;
    assign acc_nxt     = acc_q + mul_add;
    assign sticky_base = flag_clr ? 4'b0000 : sticky_q;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        sticky_d    = sticky_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (ena) begin
            sticky_d = sticky_base;
            unique case (state_q)
                IDLE: begin
                    if (start && op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_q};
                        mplier_d = b_q;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else if (start) begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        flags_d     = {alu_res == '0, alu_c, alu_v, alu_res[MSB]};
                        sticky_d    = sticky_base | {alu_res == '0, alu_c, alu_v, alu_res[MSB]};
                        done_d      = 1'b1;
                    end
                    if (in_load) begin
                        if (in_sel) b_d = in_data;
                        else        a_d = in_data;
                    end
                end
                MUL: begin
                    acc_d    = acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_d    = acc_nxt[WIDTH-1:0];
                        result_hi_d = acc_nxt[PW-1:WIDTH];
                        flags_d     = {acc_nxt == '0, acc_nxt[PW-1:WIDTH] != '0, 1'b0, acc_nxt[PW-1]};
                        sticky_d    = sticky_base |
                                      {acc_nxt == '0, acc_nxt[PW-1:WIDTH] != '0, 1'b0, acc_nxt[PW-1]};
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            sticky_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = flags_q[3];
    assign carry     = flags_q[2];
    assign overflow  = flags_q[1];
    assign negative  = flags_q[0];
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_seq_core;

    localparam int W   = 8;
    localparam int SHW = $clog2(W) + 1;

    logic           clk = 1'b0;
    logic           rst_n, ena, in_sel, in_load, start, flag_clr;
    logic [W-1:0]   in_data;
    logic [2:0]     op;
    logic [SHW-1:0] shamt;
    logic           busy, done, zero, carry, overflow, negative;
    logic [W-1:0]   result, result_hi;
    logic [3:0]     sticky;

    int checks = 0;
    int errors = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_sel(in_sel),
        .in_load(in_load), .op(op), .shamt(shamt), .start(start), .flag_clr(flag_clr),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .zero(zero), .carry(carry), .overflow(overflow), .negative(negative), .sticky(sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for single-cycle ops: returns {zero,carry,overflow,negative,result}
    function automatic logic [W+3:0] alu_ref(input int o, input int a, input int b, input int s);
        int mask, half, full, sa, sb, sr, r;
        logic c, v;
        mask = (1 << W) - 1;
        half = 1 << (W - 1);
        sa = (a >= half) ? a - (1 << W) : a;
        sb = (b >= half) ? b - (1 << W) : b;
        r = 0; c = 1'b0; v = 1'b0;
        case (o)
            0: begin full = a + b; r = full & mask; c = full > mask;
                     sr = sa + sb; v = (sr < -half) || (sr >= half); end
            1: begin full = a - b; r = full & mask; c = a < b;
                     sr = sa - sb; v = (sr < -half) || (sr >= half); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: if (s == 0) r = a;
               else if (s < W) begin r = (a << s) & mask; c = ((a >> (W - s)) & 1) != 0; end
            6: if (s == 0) r = a;
               else if (s < W) begin r = a >> s; c = ((a >> (s - 1)) & 1) != 0; end
            default: r = 0;
        endcase
        return {r == 0, c, v, r >= half, W'(r)};
    endfunction

    int         m_a, m_b, m_res, m_hi, m_left, m_prod;
    logic       m_busy, m_done;
    logic [3:0] m_flags, m_sticky;
    int         n_a, n_b, n_res, n_hi, n_left, n_prod;
    logic       n_busy, n_done;
    logic [3:0] n_flags, n_sticky, base;
    logic [W+3:0] rf;

    // Model: the product is computed whole at start; done follows after W enabled cycles
    always_comb begin
        n_a = m_a; n_b = m_b; n_res = m_res; n_hi = m_hi; n_left = m_left; n_prod = m_prod;
        n_busy = m_busy; n_done = 1'b0; n_flags = m_flags; n_sticky = m_sticky;
        base = 4'b0000; rf = '0;
        if (ena) begin
            base = flag_clr ? 4'b0000 : m_sticky;
            n_sticky = base;
            if (m_busy) begin
                n_left = m_left - 1;
                if (m_left == 1) begin
                    n_busy  = 1'b0;
                    n_done  = 1'b1;
                    n_res   = m_prod % (1 << W);
                    n_hi    = m_prod / (1 << W);
                    n_flags = {m_prod == 0, n_hi != 0, 1'b0, n_hi >= (1 << (W - 1))};
                    n_sticky = base | n_flags;
                end
            end else begin
                if (start && op == 3'b111) begin
                    n_prod = m_a * m_b;
                    n_left = W;
                    n_busy = 1'b1;
                end else if (start) begin
                    rf = alu_ref(int'(op), m_a, m_b, int'(shamt));
                    n_res = int'(rf[W-1:0]);
                    n_hi = 0;
                    n_flags = rf[W+3:W];
                    n_done = 1'b1;
                    n_sticky = base | rf[W+3:W];
                end
                if (in_load) begin
                    if (in_sel) n_b = int'(in_data);
                    else        n_a = int'(in_data);
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= 0; m_b <= 0; m_res <= 0; m_hi <= 0; m_left <= 0; m_prod <= 0;
            m_busy <= 1'b0; m_done <= 1'b0; m_flags <= 4'b0; m_sticky <= 4'b0;
        end else begin
            m_a <= n_a; m_b <= n_b; m_res <= n_res; m_hi <= n_hi; m_left <= n_left;
            m_prod <= n_prod; m_busy <= n_busy; m_done <= n_done;
            m_flags <= n_flags; m_sticky <= n_sticky;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("result", 32'(result), 32'(m_res));
        chk("result_hi", 32'(result_hi), 32'(m_hi));
        chk("flags", 32'({zero, carry, overflow, negative}), 32'(m_flags));
        chk("sticky", 32'(sticky), 32'(m_sticky));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [W-1:0] d);
        in_sel = sel; in_data = d; in_load = 1'b1;
        cyc();
        in_load = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [SHW-1:0] s);
        op = o; shamt = s; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] r, input logic [3:0] f);
        chk({name, "_done"}, 32'(done), 32'h1);
        chk({name, "_res"}, 32'(result), 32'(r));
        chk({name, "_flags"}, 32'({zero, carry, overflow, negative}), 32'(f));
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_sel = 1'b0; in_load = 1'b0; start = 1'b0;
        flag_clr = 1'b0; in_data = '0; op = 3'b000; shamt = '0;
        #12;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_done_busy", 32'({done, busy}), 32'h0);
        chk("rst_sticky", 32'(sticky), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        load(1'b0, 8'hFF); load(1'b1, 8'h01);
        run(3'b000, '0);          chk_out("add_wrap", 8'h00, 4'b1100);
        load(1'b0, 8'h7F);
        run(3'b000, '0);          chk_out("add_ovf", 8'h80, 4'b0011);
        load(1'b0, 8'h05); load(1'b1, 8'h07);
        run(3'b001, '0);          chk_out("sub_borrow", 8'hFE, 4'b0101);
        load(1'b0, 8'h81);
        run(3'b101, SHW'(1));     chk_out("shl1", 8'h02, 4'b0100);
        run(3'b110, SHW'(1));     chk_out("shr1", 8'h40, 4'b0100);
        run(3'b101, SHW'(9));     chk_out("shl9", 8'h00, 4'b1000);
        run(3'b110, SHW'(8));     chk_out("shr8", 8'h00, 4'b1000);
        run(3'b101, SHW'(0));     chk_out("shl0", 8'h81, 4'b0001);
        run(3'b101, SHW'(7));     chk_out("shl7", 8'h80, 4'b0001);
        load(1'b1, 8'h3C);
        run(3'b100, '0);
        run(3'b011, '0);
        run(3'b010, '0);
        op = 3'b001; start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        cyc();

        // MUL with start/load pulses while busy
        load(1'b0, 8'hFF); load(1'b1, 8'hFF);
        run(3'b111, '0);
        chk("mul_busy_start", 32'(busy), 32'h1);
        for (int i = 1; i <= W - 1; i++) begin
            if (i == 2) begin in_sel = 1'b0; in_data = 8'h00; in_load = 1'b1; end
            if (i == 4) begin op = 3'b000; start = 1'b1; end
            cyc();
            in_load = 1'b0; start = 1'b0;
            chk("mul_busy_hold", 32'({busy, done}), 32'h2);
        end
        cyc();
        chk_out("mul_ff", 8'h01, 4'b0101);
        chk("mul_ff_hi", 32'(result_hi), 32'hFE);
        chk("mul_ff_busy", 32'(busy), 32'h0);
        run(3'b000, '0);          chk_out("add_after_mul", 8'hFE, 4'b0101);

        // MUL stretched by an ena gap
        load(1'b0, 8'h0D); load(1'b1, 8'h0B);
        run(3'b111, '0);
        cyc(); cyc();
        ena = 1'b0;
        cyc(); cyc(); cyc();
        ena = 1'b1;
        for (int i = 0; i < W + 2; i++) cyc();
        chk("mul_gap_res", 32'({result_hi, result}), 32'h008F);

        // Reset in the middle of a MUL
        load(1'b0, 8'h12); load(1'b1, 8'h34);
        run(3'b111, '0);
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'({busy, done, result_hi, result}), 32'h0);
        chk("midrst_flags", 32'({zero, carry, overflow, negative, sticky}), 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        load(1'b0, 8'h0D); load(1'b1, 8'h0B);
        run(3'b111, '0);
        for (int i = 0; i < W - 1; i++) cyc();
        chk("postrst_nodone", 32'(done), 32'h0);
        cyc();
        chk_out("postrst_mul", 8'h8F, 4'b0000);
        chk("postrst_hi", 32'(result_hi), 32'h00);

        // Sticky flags
        flag_clr = 1'b1; cyc(); flag_clr = 1'b0;
        chk("sticky_clr0", 32'(sticky), 32'h0);
        load(1'b0, 8'hFF); load(1'b1, 8'h02);
        run(3'b000, '0);          chk_out("add_carry", 8'h01, 4'b0100);
        load(1'b1, 8'h00);
        run(3'b010, '0);          chk_out("and_zero", 8'h00, 4'b1000);
        chk("sticky_acc", 32'(sticky), 32'hC);
        flag_clr = 1'b1; cyc(); flag_clr = 1'b0;
        chk("sticky_clr", 32'(sticky), 32'h0);
        load(1'b0, 8'h7F); load(1'b1, 8'h01);
        flag_clr = 1'b1;
        run(3'b000, '0);
        flag_clr = 1'b0;
        chk("sticky_clr_done", 32'(sticky), 32'h3);

        // ena low: start and load ignored
        ena = 1'b0; start = 1'b1; op = 3'b001; in_load = 1'b1; in_sel = 1'b0; in_data = 8'h00;
        cyc(); cyc(); cyc();
        chk("ena0_done", 32'(done), 32'h0);
        chk("ena0_result", 32'(result), 32'h80);
        start = 1'b0; in_load = 1'b0; ena = 1'b1;
        cyc();
        run(3'b000, '0);          chk_out("ena0_after", 8'h80, 4'b0011);
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
